// File: rtl/rr_mux_arbiter.sv
// Round-robin owner of a shared 4:1 LED mux.
// One requester at a time is granted; its data bit is forwarded to the LED.
// Under contention the grant rotates after HOLD_CYCLES cycles. A requester
// that drops its request gives the grant up at the same edge.
module rr_mux_arbiter #(
  parameter int unsigned HOLD_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] din,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       led,
  output logic       valid
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       grant_q, grant_d;
  logic             led_q, led_d;
  logic             valid_q, valid_d;
  logic [3:0]       others_s;

  // First requester found scanning start, start+1, ... with 2-bit wrap.
  // Returns start when nothing is requesting; callers never rely on that case.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] res;
    logic [1:0] cand;
    logic       found;
    res   = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = start + 2'(k);
      if (!found && r[cand]) begin
        res   = cand;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Binary index to one-hot grant vector.
  function automatic logic [3:0] onehot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  // Arbitration decision and next values of every registered output.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    others_s = req & ~onehot(idx_q);

    case (state_q)
      ST_IDLE: begin
        if (req != 4'b0000) begin
          // A fresh grant does not move the round-robin pointer.
          state_d = ST_GRANT;
          idx_d   = pick(req, ptr_q);
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!req[idx_q]) begin
          // Release wins over expiry; hand over without an idle cycle if possible.
          ptr_d = idx_q + 2'd1;
          cnt_d = '0;
          if (others_s != 4'b0000) begin
            idx_d = pick(req, idx_q + 2'd1);
          end else begin
            state_d = ST_IDLE;
          end
        end else if (cnt_q == CNT_MAX) begin
          // Hold time used up: rotate only if someone else is waiting.
          cnt_d = '0;
          if (others_s != 4'b0000) begin
            idx_d = pick(req, idx_q + 2'd1);
            ptr_d = idx_q + 2'd1;
          end else begin
            idx_d = idx_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs follow the next state so they change on the same edge as idx.
    if (state_d == ST_GRANT) begin
      sel_d   = idx_d;
      grant_d = onehot(idx_d);
      led_d   = din[idx_d];
      valid_d = 1'b1;
    end else begin
      sel_d   = sel_q;
      grant_d = 4'b0000;
      led_d   = 1'b0;
      valid_d = 1'b0;
    end
  end

  // State, pointer, counter and output registers; reset aborts any grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      sel_q   <= 2'd0;
      grant_q <= 4'b0000;
      led_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      led_q   <= led_d;
      valid_q <= valid_d;
    end
  end

  assign sel   = sel_q;
  assign grant = grant_q;
  assign led   = led_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter with HOLD_CYCLES=4: directed scenarios with
// constant expectations, then random traffic against a reference model
// feeding a scoreboard queue that an independent monitor drains.
module tb_rr_mux_arbiter;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] din;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       led;
  logic       valid;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] grant;
    logic       led;
    logic       valid;
  } exp_t;

  exp_t exp_q[$];

  rr_mux_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .din   (din),
    .sel   (sel),
    .grant (grant),
    .led   (led),
    .valid (valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Index of first requester at or after s, going round the ring; -1 if none.
  function automatic int first_from(input logic [3:0] r, input int s);
    for (int k = 0; k < 4; k++) begin
      if (r[(s + k) % 4]) return (s + k) % 4;
    end
    return -1;
  endfunction

  // Reference model: who owns the LED, how long they have had it, and where
  // the next search starts. Pushes the outputs expected after every edge.
  initial begin
    bit   busy;
    int   owner;
    int   nxt_ptr;
    int   held;
    int   last_sel;
    int   n;
    exp_t e;
    busy = 0; owner = 0; nxt_ptr = 0; held = 0; last_sel = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        busy = 0; owner = 0; nxt_ptr = 0; held = 0; last_sel = 0;
      end else begin
        if (!busy) begin
          n = first_from(req, nxt_ptr);
          if (n >= 0) begin
            busy = 1; owner = n; held = 1;
          end
        end else if (!req[owner]) begin
          nxt_ptr = (owner + 1) % 4;
          n = first_from(req, nxt_ptr);
          if (n >= 0) begin
            owner = n; held = 1;
          end else begin
            busy = 0;
          end
        end else if (held == HOLD) begin
          n = first_from(req, (owner + 1) % 4);
          if (n != owner) begin
            nxt_ptr = (owner + 1) % 4;
            owner = n;
          end
          held = 1;
        end else begin
          held++;
        end
        if (busy) last_sel = owner;
        e.sel   = 2'(last_sel);
        e.grant = busy ? (4'b0001 << owner) : 4'b0000;
        e.led   = busy ? din[owner] : 1'b0;
        e.valid = busy;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: pops the expected response after every edge out of reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        chk("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sb_grant", grant, e.grant);
          chk("sb_sel", sel, e.sel);
          chk("sb_led", led, e.led);
          chk("sb_valid", valid, e.valid);
        end
        chk("onehot", $countones(grant) <= 1, 1);
        chk("valid_vs_grant", valid, grant != 4'b0000);
      end
    end
  end

  task automatic drive(input logic [3:0] r, input logic [3:0] d);
    @(negedge clk);
    req = r;
    din = d;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    din   = 4'b0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single requester: immediate grant, long hold, data follows din.
    drive(4'b0010, 4'b0010);
    after_edge();
    chk("single_grant", grant, 4'b0010);
    chk("single_sel", sel, 2'b01);
    chk("single_led", led, 1'b1);
    chk("single_valid", valid, 1'b1);
    repeat (22) @(negedge clk);
    chk("single_hold", grant, 4'b0010);
    drive(4'b0010, 4'b0000);
    after_edge();
    chk("single_din_drop", led, 1'b0);

    // Reset mid-grant with everyone requesting.
    drive(4'b1111, 4'b0101);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_grant", grant, 4'b0000);
    chk("rst_sel", sel, 2'b00);
    chk("rst_led", led, 1'b0);
    chk("rst_valid", valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full contention: four-cycle slots 0,1,2,3,0 with led 1,0,1,0.
    for (int j = 0; j < 18; j++) begin
      after_edge();
      chk("rr_grant", grant, 4'b0001 << ((j / 4) % 4));
      chk("rr_led", led, ((j / 4) % 2) == 0);
    end

    // Early release while index 0 is at count 1.
    drive(4'b1110, 4'b0101);
    after_edge();
    chk("early_grant", grant, 4'b0010);
    chk("early_valid", valid, 1'b1);

    // Move to index 2, then everyone drops: idle, pointer now 3.
    drive(4'b0100, 4'b0101);
    after_edge();
    chk("to2_grant", grant, 4'b0100);
    drive(4'b0000, 4'b0101);
    after_edge();
    chk("idle_valid", valid, 1'b0);
    chk("idle_led", led, 1'b0);
    chk("idle_sel", sel, 2'b10);
    drive(4'b1111, 4'b0101);
    after_edge();
    chk("ptr_grant", grant, 4'b1000);

    // Wrap from 3 to 0 skipping idle requesters 1 and 2.
    drive(4'b1001, 4'b0101);
    for (int j = 0; j < 3; j++) begin
      after_edge();
      chk("wrap_hold", grant, 4'b1000);
    end
    after_edge();
    chk("wrap_grant", grant, 4'b0001);

    // Random traffic with sticky requests and occasional resets.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
      din = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("rand_rst_grant", grant, 4'b0000);
        chk("rand_rst_valid", valid, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    end

    after_edge();
    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin controller that shares one 4:1 mux output (the board LED) between four requesters. It owns the mux select: it picks one active requester, drives `sel`/`grant` for it, and forwards that requester's data bit to `led`. The grant rotates after a programmable hold time whenever another requester is waiting. It sits between the switch-conditioning logic and the LED pin.

## Interface

- `HOLD_CYCLES`, default 100_000_000: grant hold time in clock cycles before rotation is allowed. Legal range ≥ 2. 1 s at 100 MHz.
- `clk` in 1: system clock, rising-edge active.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in 4: request per requester. Synchronous to `clk`; synchronizers sit upstream.
- `din` in 4: data bit per requester. `din[i]` belongs to `req[i]`.
- `sel` out 2: mux select, the binary index of the granted requester.
- `grant` out 4: one-hot grant, or 0000 when idle.
- `led` out 1: registered `din[sel]` while granted, otherwise 0.
- `valid` out 1: high while a grant is active.

## Operation

- **States:** IDLE and GRANT. All outputs are registered.
- **Internal registers:**
  - `ptr` (2 bits): round-robin start index.
  - `cnt`: hold counter, width `$clog2(HOLD_CYCLES)`.
  - `idx` (2 bits): the granted index.
- **Arbitration function:** `pick(start)` returns the first index i with `req[i]=1`, scanning `start, start+1, …` modulo 4.
- **IDLE:**
  - Outputs: `grant`=0000, `valid`=0, `led`=0. `sel` holds its last value.
  - If `req`≠0000, go to GRANT with `idx`=`pick(ptr)` and `cnt`=0.
- **GRANT, evaluated every cycle in priority order:**
  1. **Release:** `req[idx]`=0. Set `ptr`=`idx`+1.
     - If other requests are present, re-grant `pick(idx+1)` directly (GRANT→GRANT, no idle cycle) and set `cnt`=0.
     - Otherwise go to IDLE.
  2. **Hold expiry:** `cnt`=`HOLD_CYCLES`−1.
     - If any other requester is active, rotate: new `idx`=`pick(idx+1)`, `ptr`=`idx`+1, `cnt`=0.
     - If no other requester is active, keep `idx` and set `cnt`=0, so the sole requester keeps the grant indefinitely.
  3. **Otherwise:** `cnt`=`cnt`+1.
- **Output updates:** `grant`, `sel` and `valid` update at the same edge as `idx`. `led` loads `din[new idx]` at that edge and reloads `din[idx]` every following edge while granted.
- **Pointer update:** `ptr` changes only on release or rotation. A new grant from IDLE leaves `ptr` unchanged.
- **Arithmetic:** all index arithmetic is modulo 4 (natural 2-bit wrap). `cnt` never exceeds `HOLD_CYCLES`−1.

## Timing

- **Reset values:** while `rst_n`=0, outputs are forced immediately (asynchronously) to `sel`=00, `grant`=0000, `led`=0, `valid`=0. Internal state is `ptr`=0, `cnt`=0, state IDLE.
- **Reset mid-grant:** the grant aborts immediately. After release of reset, arbitration restarts from index 0.
- **Grant latency:** `req` sampled high at edge k gives `grant`/`sel`/`valid`/`led` valid after edge k.
- **Data latency:** a `din` change while granted appears on `led` one edge later.
- **Release latency:** `req[idx]` sampled low at edge k means that by edge k the new grant, or IDLE, is in place. The dropped requester never holds the grant past that edge.
- **Hold time:** with contention, each requester holds the grant for exactly `HOLD_CYCLES` cycles.
- **No-overlap rule:** `grant` is never multi-hot. There is never a cycle with `valid`=1 and `grant`=0000.
- **Simultaneous events:** release takes precedence over expiry on the same cycle. A new request arriving on the same edge as a release or rotation is included in that `pick`.

## Test plan

All scenarios use `HOLD_CYCLES`=4.

1. **Reset values:** assert `rst_n`=0 mid-simulation with `req`=1111 → asynchronously `grant`=0000, `sel`=00, `led`=0, `valid`=0. After release of reset, the first grant is 0001.
2. **Single requester:** `req`=0010, `din`=0010 from IDLE → one edge later `grant`=0010, `sel`=01, `led`=1, `valid`=1. The grant is held for 20+ cycles with no rotation. Toggling `din[1]` to 0 gives `led`=0 one edge later.
3. **Full contention:** `req`=1111, `din`=0101 → `grant` sequence is 0001 ×4 cycles, then 0010 ×4, 0100 ×4, 1000 ×4, then 0001 again. `led` sequence is 1, 0, 1, 0 per slot.
4. **Early release:** with 0001 granted at `cnt`=1, change `req` to 1110 → next edge `grant`=0010 with `cnt`=0, and no IDLE cycle in between.
5. **Idle and pointer memory:** with 0100 granted, `req` goes to 0000 → next edge IDLE with `led`=0 and `valid`=0. Then `req`=1111 → `grant`=1000, because `ptr`=3.
6. **Wrap-around and skipping:** `req`=1001 with 1000 granted, at hold expiry → `grant`=0001. Indices 1 and 2 are skipped, and `grant` stays one-hot throughout.
